// File: rtl/adder_eval_pkg.sv
// adder_eval_pkg: shared FSM state type, default sizes and saturating add for adder_error_monitor.
package adder_eval_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_ACC_W = 48;
  localparam int SAT_W = 128;
  // Operands are zero-extended into a wide domain so the sum never wraps before clamping.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] x, input logic [SAT_W-1:0] y, input int w);
    logic [SAT_W-1:0] lim;
    logic [SAT_W-1:0] s;
    lim = (SAT_W'(1) << w) - SAT_W'(1);
    s = x + y;
    return s > lim ? lim : s;
  endfunction
endpackage

// File: rtl/err_stat_acc.sv
// err_stat_acc: stage-2 abs error and saturating statistics; ADDER_ERR_SQ_EN adds a squared-error accumulator.
module err_stat_acc
  import adder_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             valid,
  input  logic [WIDTH:0]   exact,
  input  logic [WIDTH:0]   approx,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [WIDTH:0]   max_abs_err
`ifdef ADDER_ERR_SQ_EN
  ,
  output logic [2*ACC_W-1:0] sum_sq_err
`endif
);
  logic signed [WIDTH+1:0] diff;
  logic [WIDTH:0] abs_v;
  logic [CNT_W-1:0] sc_q, sc_d, ec_q, ec_d;
  logic [ACC_W-1:0] sa_q, sa_d;
  logic [WIDTH:0] mx_q, mx_d;
  assign diff = $signed({1'b0, approx}) - $signed({1'b0, exact});
  assign abs_v = (WIDTH+1)'(diff[WIDTH+1] ? -diff : diff);
  always_comb begin
    sc_d = valid ? CNT_W'(sat_add(SAT_W'(sc_q), SAT_W'(1), CNT_W)) : sc_q;
    ec_d = valid && abs_v != '0 ? CNT_W'(sat_add(SAT_W'(ec_q), SAT_W'(1), CNT_W)) : ec_q;
    sa_d = valid ? ACC_W'(sat_add(SAT_W'(sa_q), SAT_W'(abs_v), ACC_W)) : sa_q;
    mx_d = valid && abs_v > mx_q ? abs_v : mx_q;
  end
  always_ff @(posedge clk) begin
    sc_q <= clr ? '0 : sc_d;
    ec_q <= clr ? '0 : ec_d;
    sa_q <= clr ? '0 : sa_d;
    mx_q <= clr ? '0 : mx_d;
  end
  assign sample_count = sc_q;
  assign err_count = ec_q;
  assign sum_abs_err = sa_q;
  assign max_abs_err = mx_q;
`ifdef ADDER_ERR_SQ_EN
  logic [2*WIDTH+1:0] sq;
  logic [2*ACC_W-1:0] sq_q, sq_d;
  assign sq = {{(WIDTH+1){1'b0}}, abs_v} * {{(WIDTH+1){1'b0}}, abs_v};
  assign sq_d = valid ? (2*ACC_W)'(sat_add(SAT_W'(sq_q), SAT_W'(sq), 2*ACC_W)) : sq_q;
  always_ff @(posedge clk) begin
    sq_q <= clr ? '0 : sq_d;
  end
  assign sum_sq_err = sq_q;
`endif
endmodule

// File: rtl/adder_error_monitor.sv
// adder_error_monitor: run control and stage 1 for approximate-adder error statistics; ADDER_ERR_SQ_EN adds sum_sq_err.
module adder_error_monitor
  import adder_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] cfg_num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [WIDTH:0]   max_abs_err
`ifdef ADDER_ERR_SQ_EN
  ,
  output logic [2*ACC_W-1:0] sum_sq_err
`endif
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] tgt_q, tgt_d, acc_q, acc_d;
  logic s1_v_q;
  logic [WIDTH:0] s1_exact_q, s1_approx_q;
  logic accept, launch;
  assign in_ready = state_q == RUN;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign res_valid = state_q == DONE;
  assign accept = in_valid && in_ready;
  assign launch = start && state_q == IDLE && !clear;
  always_comb begin
    state_d = state_q;
    tgt_d = launch ? cfg_num_samples : tgt_q;
    acc_d = launch ? '0 : acc_q + CNT_W'(accept);
    case (state_q)
      IDLE:  state_d = !launch ? IDLE : cfg_num_samples == '0 ? DRAIN : RUN;
      RUN:   state_d = accept && acc_q == tgt_q - CNT_W'(1) ? DRAIN : RUN;
      DRAIN: state_d = s1_v_q ? DRAIN : DONE;
      DONE:  state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    tgt_q <= rst ? '0 : tgt_d;
    acc_q <= rst || clear ? '0 : acc_d;
    s1_v_q <= !(rst || clear) && accept;
    s1_exact_q <= {1'b0, a} + {1'b0, b};
    s1_approx_q <= approx_sum;
  end
  err_stat_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_acc (
    .clk(clk),
    .clr(rst || clear || launch),
    .valid(s1_v_q),
    .exact(s1_exact_q),
    .approx(s1_approx_q),
    .sample_count(sample_count),
    .err_count(err_count),
    .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err)
`ifdef ADDER_ERR_SQ_EN
    ,
    .sum_sq_err(sum_sq_err)
`endif
  );
endmodule

// File: tb/tb_adder_error_monitor.sv
// tb_adder_error_monitor: randomized self-checking bench with a queue-based error model; a second ACC_W=8 instance covers saturation.
module tb_adder_error_monitor;
  logic clk = 0;
  logic rst, start, clear, in_valid, res_ready;
  logic [31:0] cfg;
  logic [15:0] a, b;
  logic [16:0] approx_sum;
  logic in_ready, busy, res_valid;
  logic [31:0] sample_count, err_count;
  logic [47:0] sum_abs_err;
  logic [16:0] max_abs_err;
  logic [95:0] sum_sq_err;
  logic s_in_ready, s_busy, s_res_valid;
  logic [31:0] s_sc, s_ec;
  logic [7:0] s_sa;
  logic [16:0] s_mx;
  logic [15:0] s_sq;
  int checks = 0, errors = 0, cyc = 0;
  logic [15:0] qa[$], qb[$];
  logic [16:0] qs[$];
  longint e_sc, e_ec, e_sa, e_mx, e_sq;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_error_monitor dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .cfg_num_samples(cfg),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx_sum(approx_sum),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .sample_count(sample_count), .err_count(err_count), .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err)
`ifdef ADDER_ERR_SQ_EN
    , .sum_sq_err(sum_sq_err)
`endif
  );

  adder_error_monitor #(.ACC_W(8)) u_sat (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .cfg_num_samples(cfg),
    .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .approx_sum(approx_sum),
    .busy(s_busy), .res_valid(s_res_valid), .res_ready(res_ready),
    .sample_count(s_sc), .err_count(s_ec), .sum_abs_err(s_sa), .max_abs_err(s_mx)
`ifdef ADDER_ERR_SQ_EN
    , .sum_sq_err(s_sq)
`endif
  );

  // Reference: error is the integer difference approx-(a+b); accumulators clamp at 2^accw-1.
  function automatic void model(input int accw);
    longint lim;
    lim = (longint'(1) << accw) - 1;
    e_sc = 0; e_ec = 0; e_sa = 0; e_mx = 0; e_sq = 0;
    foreach (qa[i]) begin
      int d;
      int ab;
      d = int'(qs[i]) - int'(qa[i]) - int'(qb[i]);
      ab = d < 0 ? -d : d;
      e_sc++;
      if (ab != 0) e_ec++;
      e_sa = e_sa + ab > lim ? lim : e_sa + ab;
      if (ab > e_mx) e_mx = ab;
      e_sq = e_sq + longint'(ab) * ab;
    end
    if (e_sq > (longint'(1) << (2 * accw)) - 1 && accw < 32) e_sq = (longint'(1) << (2 * accw)) - 1;
  endfunction

  task automatic do_start(input int n, output int t);
    cfg = n; start = 1; t = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic feed(input int gap, output int la);
    la = cyc;
    for (int i = 0; i < qa.size(); i++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin in_valid = 0; @(negedge clk); end
      in_valid = 1; a = qa[i]; b = qb[i]; approx_sum = qs[i];
      for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
      checks++;
      if (!in_ready) begin errors++; $display("FAIL feed_timeout beat %0d in_ready=%0b required 1", i, in_ready); end
      la = cyc;
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic wait_done(output int t);
    for (int k = 0; k < 40 && !res_valid; k++) @(negedge clk);
    t = cyc;
    checks++;
    if (!res_valid) begin errors++; $display("FAIL done_timeout res_valid=%0b required 1", res_valid); end
  endtask

  task automatic ack();
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  task automatic rand_beat(input int mode);
    logic [15:0] x, y;
    logic [16:0] s;
    x = 16'($urandom); y = 16'($urandom);
    s = 17'({1'b0, x} + {1'b0, y});
    if (mode == 1) s = 17'(s + 17'($urandom_range(1, 300)));
    if (mode == 2) s = 17'(s - 17'($urandom_range(1, 300)));
    if (mode == 3) s = 17'($urandom);
    qa.push_back(x); qb.push_back(y); qs.push_back(s);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; clear = 0; in_valid = 0; res_ready = 0; cfg = 0; a = 0; b = 0; approx_sum = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, res_valid} !== 3'b000) begin errors++; $display("FAIL reset_ctrl in_ready/busy/res_valid=%b required 000", {in_ready, busy, res_valid}); end
    checks++;
    if ({sample_count, err_count, sum_abs_err, max_abs_err} !== '0) begin errors++; $display("FAIL reset_stats sc=%0d ec=%0d sa=%0d mx=%0d required all 0", sample_count, err_count, sum_abs_err, max_abs_err); end
  endtask

  task automatic test_exact();
    int t0, la, t;
    qa = '{16'd1, 16'hFFFF, 16'd5, 16'd0};
    qb = '{16'd2, 16'd1, 16'd5, 16'd0};
    qs = '{17'd3, 17'h10000, 17'd10, 17'd0};
    do_start(4, t0);
    checks++;
    if ({busy, in_ready} !== 2'b11) begin errors++; $display("FAIL exact_run busy/in_ready=%b required 11", {busy, in_ready}); end
    feed(0, la);
    wait_done(t);
    checks++;
    if (t - la !== 3) begin errors++; $display("FAIL exact_latency got %0d required 3", t - la); end
    checks++;
    if ({sample_count, err_count, sum_abs_err, max_abs_err} !== {32'd4, 32'd0, 48'd0, 17'd0}) begin errors++; $display("FAIL exact_stats sc=%0d ec=%0d sa=%0d mx=%0d required 4 0 0 0", sample_count, err_count, sum_abs_err, max_abs_err); end
    ack();
    checks++;
    if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL exact_ack res_valid/busy=%b required 00", {res_valid, busy}); end
    checks++;
    if (sample_count !== 32'd4) begin errors++; $display("FAIL exact_hold sc=%0d required 4", sample_count); end
  endtask

  task automatic test_errored();
    int t0, la, t;
    qa = '{16'h0F, 16'h100, 16'd7};
    qb = '{16'h01, 16'h100, 16'd9};
    qs = '{17'h00, 17'h200, 17'h12};
    do_start(3, t0);
    feed(0, la);
    wait_done(t);
    model(48);
    checks++;
    if (t - la !== 3) begin errors++; $display("FAIL err_latency got %0d required 3", t - la); end
    checks++;
    if ({sample_count, err_count, sum_abs_err, max_abs_err} !== {32'd3, 32'd2, 48'h12, 17'h10}) begin errors++; $display("FAIL err_stats sc=%0d ec=%0d sa=%0h mx=%0h required 3 2 12 10", sample_count, err_count, sum_abs_err, max_abs_err); end
    checks++;
    if (sum_abs_err !== 48'(e_sa) || max_abs_err !== 17'(e_mx)) begin errors++; $display("FAIL err_model sa=%0h mx=%0h required %0h %0h", sum_abs_err, max_abs_err, e_sa, e_mx); end
    ack();
  endtask

  task automatic test_backpressure();
    int t0, n, la, t;
    logic rdy_after;
    qa.delete(); qb.delete(); qs.delete();
    n = 0; la = -10; rdy_after = 1'bx;
    do_start(2, t0);
    in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      if (n == 2 && cyc == la + 1) rdy_after = in_ready;
      a = 16'($urandom); b = 16'($urandom); approx_sum = 17'($urandom);
      if (in_ready) begin
        n++; qa.push_back(a); qb.push_back(b); qs.push_back(approx_sum);
        if (n == 2) la = cyc;
      end
      @(negedge clk);
    end
    in_valid = 0;
    checks++;
    if (n !== 2) begin errors++; $display("FAIL bp_accepts got %0d required 2", n); end
    checks++;
    if (rdy_after !== 1'b0) begin errors++; $display("FAIL bp_ready_drop in_ready=%b required 0", rdy_after); end
    wait_done(t);
    model(48);
    checks++;
    if (sample_count !== 32'd2 || err_count !== 32'(e_ec) || sum_abs_err !== 48'(e_sa)) begin errors++; $display("FAIL bp_stats sc=%0d ec=%0d sa=%0d required 2 %0d %0d", sample_count, err_count, sum_abs_err, e_ec, e_sa); end
    ack();
  endtask

  task automatic test_zero_ignored();
    int t0, la, t;
    do_start(0, t0);
    wait_done(t);
    checks++;
    if (t - t0 !== 2) begin errors++; $display("FAIL zero_latency got %0d required 2", t - t0); end
    checks++;
    if ({sample_count, err_count, sum_abs_err, max_abs_err} !== '0) begin errors++; $display("FAIL zero_stats sc=%0d ec=%0d sa=%0d mx=%0d required 0", sample_count, err_count, sum_abs_err, max_abs_err); end
    cfg = 7; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({res_valid, busy, in_ready} !== 3'b100 || sample_count !== 0) begin errors++; $display("FAIL done_start_ignored rv/busy/rdy=%b sc=%0d required 100 0", {res_valid, busy, in_ready}, sample_count); end
    ack();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL zero_ack res_valid=%b required 0", res_valid); end
    qa.delete(); qb.delete(); qs.delete();
    rand_beat(1);
    do_start(1, t0);
    feed(0, la);
    wait_done(t);
    model(48);
    checks++;
    if (sample_count !== 32'd1 || sum_abs_err !== 48'(e_sa)) begin errors++; $display("FAIL restart sc=%0d sa=%0d required 1 %0d", sample_count, sum_abs_err, e_sa); end
    ack();
  endtask

  task automatic test_clear();
    int t0, la, t;
    qa.delete(); qb.delete(); qs.delete();
    for (int i = 0; i < 4; i++) rand_beat(1);
    do_start(10, t0);
    feed(0, la);
    checks++;
    if (busy !== 1'b1 || sample_count === 0) begin errors++; $display("FAIL clear_pre busy=%b sc=%0d required 1 and nonzero", busy, sample_count); end
    clear = 1;
    @(negedge clk);
    clear = 0;
    checks++;
    if ({busy, in_ready, res_valid} !== 3'b000) begin errors++; $display("FAIL clear_ctrl busy/rdy/rv=%b required 000", {busy, in_ready, res_valid}); end
    checks++;
    if ({sample_count, err_count, sum_abs_err, max_abs_err} !== '0) begin errors++; $display("FAIL clear_stats sc=%0d ec=%0d sa=%0d mx=%0d required 0", sample_count, err_count, sum_abs_err, max_abs_err); end
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, sample_count} !== 33'd0) begin errors++; $display("FAIL clear_flush busy=%b sc=%0d required 0 0", busy, sample_count); end
    qa.delete(); qb.delete(); qs.delete();
    rand_beat(3);
    do_start(1, t0);
    feed(0, la);
    wait_done(t);
    model(48);
    checks++;
    if (t - la !== 3 || sample_count !== 32'd1 || err_count !== 32'(e_ec) || max_abs_err !== 17'(e_mx)) begin errors++; $display("FAIL clear_rerun lat=%0d sc=%0d ec=%0d mx=%0d required 3 1 %0d %0d", t - la, sample_count, err_count, max_abs_err, e_ec, e_mx); end
    ack();
  endtask

  task automatic test_random();
    int t0, la, t, n;
    for (int r = 0; r < 4; r++) begin
      qa.delete(); qb.delete(); qs.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) rand_beat($urandom_range(0, 3));
      do_start(n, t0);
      feed(30, la);
      wait_done(t);
      checks++;
      if (t - la !== 3) begin errors++; $display("FAIL rand_latency run %0d got %0d required 3", r, t - la); end
      model(48);
      checks++;
      if (sample_count !== 32'(e_sc) || err_count !== 32'(e_ec) || sum_abs_err !== 48'(e_sa) || max_abs_err !== 17'(e_mx)) begin
        errors++; $display("FAIL rand_stats run %0d sc=%0d ec=%0d sa=%0d mx=%0d required %0d %0d %0d %0d", r, sample_count, err_count, sum_abs_err, max_abs_err, e_sc, e_ec, e_sa, e_mx);
      end
`ifdef ADDER_ERR_SQ_EN
      checks++;
      if (sum_sq_err !== 96'(e_sq)) begin errors++; $display("FAIL rand_sq run %0d got %0d required %0d", r, sum_sq_err, e_sq); end
`endif
      model(8);
      checks++;
      if (s_sa !== 8'(e_sa)) begin errors++; $display("FAIL rand_sat8 run %0d got %0d required %0d", r, s_sa, e_sa); end
      ack();
    end
  endtask

  task automatic test_saturation();
    int t0, la, t;
    qa = '{16'd0, 16'd1, 16'h10};
    qb = '{16'd0, 16'd1, 16'd0};
    qs = '{17'h80, 17'h82, 17'h90};
    do_start(3, t0);
    feed(0, la);
    wait_done(t);
    checks++;
    if (s_sa !== 8'hFF) begin errors++; $display("FAIL sat_acc got %0h required ff", s_sa); end
    checks++;
    if (sum_abs_err !== 48'h180 || s_mx !== 17'h80 || s_ec !== 32'd3) begin errors++; $display("FAIL sat_wide sa=%0h mx=%0h ec=%0d required 180 80 3", sum_abs_err, s_mx, s_ec); end
    ack();
`ifdef ADDER_ERR_SQ_EN
    qa = '{16'd20}; qb = '{16'd30}; qs = '{17'd53};
    do_start(1, t0);
    feed(0, la);
    wait_done(t);
    checks++;
    if (sum_sq_err !== 96'd9 || s_sq !== 16'd9) begin errors++; $display("FAIL sq_nine got %0d/%0d required 9", sum_sq_err, s_sq); end
    ack();
`endif
  endtask

  initial begin
    test_reset();
    test_exact();
    test_errored();
    test_backpressure();
    test_zero_ignored();
    test_clear();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_error_monitor.md
# adder_error_monitor

Sequential error-evaluation block sitting downstream of a combinational approximate 16-bit adder under test. It accepts a stream of operand pairs together with the approximate 17-bit sum the adder produced, recomputes the exact sum internally, and accumulates error statistics over a programmed number of samples. The statistics are error count, sum of absolute error distance and maximum absolute error. Results are presented through a valid/ready result port for the characterization flow.

## Interface
- WIDTH, 16, operand width; sums are WIDTH+1 bits
- CNT_W, 32, width of sample and error counters
- ACC_W, 48, width of absolute-error accumulator
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse: begin a run of cfg_num_samples
- clear  in  1  abort run, zero statistics, return to IDLE
- cfg_num_samples  in  CNT_W  samples per run, sampled on start
- in_valid  in  1  sample beat valid
- in_ready  out  1  block can accept a beat
- a, b  in  WIDTH  operands applied to the adder under test
- approx_sum  in  WIDTH+1  adder-under-test output for a, b
- busy  out  1  run in progress (RUN or DRAIN)
- res_valid  out  1  results stable and valid
- res_ready  in  1  consumer accepts results
- sample_count  out  CNT_W  beats retired this run
- err_count  out  CNT_W  beats with approx_sum != a+b
- sum_abs_err  out  ACC_W  sum of |approx_sum - (a+b)|
- max_abs_err  out  WIDTH+1  largest single |error|
- sum_sq_err  out  2*ACC_W  sum of squared error (only with ADDER_ERR_SQ_EN)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. On start, latch cfg_num_samples and zero all statistics. Go to RUN, or go to DRAIN if cfg_num_samples=0.
- RUN: in_ready=1 while accepted < target. A beat is accepted when in_valid&&in_ready. When the target-th beat is accepted, in_ready drops the next cycle and the FSM goes to DRAIN.
- DRAIN: in_ready=0. Wait until the pipeline is empty, then go to DONE.
- DONE: res_valid=1. On res_ready, go to IDLE; statistics hold their values until the next start.
- Stage 1 registers: exact = a+b (WIDTH+1 bits, zero-extended), approx, and a beat-valid bit.
- Stage 2 computes diff = approx - exact as a signed WIDTH+2-bit value, then abs = |diff|. It updates sample_count+1, err_count+(abs!=0), sum_abs_err+abs, and max_abs_err=max(max_abs_err,abs).
- All accumulators saturate at all-ones and never wrap.
- start while busy or in DONE: ignored.
- clear has priority over start and beats in every state. It flushes the pipeline and zeros statistics; the FSM reaches IDLE the next cycle.
- rst is equivalent to clear and also zeros the latched target.

## Timing
- Reset values: in_ready=0, busy=0, res_valid=0, all statistics 0, FSM=IDLE.
- Beat accepted in cycle N updates the statistics at edge N+2 (2-cycle latency).
- Throughput: one beat per cycle, with no bubbles while in_valid is held.
- Last beat accepted at N: DRAIN at N+1, DONE (res_valid=1) at N+3.
- cfg_num_samples=0: start at N gives res_valid at N+2 with all-zero statistics.
- res_valid&&res_ready at N gives IDLE and res_valid=0 at N+1. start is honoured from N+1.
- busy=1 exactly in RUN and DRAIN.

## Configuration
- ADDER_ERR_SQ_EN defined: stage 2 also squares abs, and that squared value feeds a saturating 2*ACC_W accumulator on sum_sq_err. Latency is unchanged because the squarer sits inside stage 2.
- Not defined: the sum_sq_err port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package adder_eval_pkg: the FSM state enum, the default WIDTH/CNT_W/ACC_W constants, and a saturating-add function.
- One sub-module, err_stat_acc: the stage-2 abs/accumulate/saturate datapath, instantiated once. The FSM and stage 1 stay in the top module.

## Test plan
- Exact stream: cfg=4, beats (1,2,3), (0xFFFF,1,0x10000), (5,5,10), (0,0,0). Expect sample_count=4, err_count=0, sum_abs_err=0, max_abs_err=0, and res_valid 3 cycles after the last accept.
- Errored stream: cfg=3, beats (0x0F,0x01,0x00), (0x100,0x100,0x200), (7,9,0x12). Expect errors 0x10, 0, 2. Result: err_count=2, sum_abs_err=0x12, max_abs_err=0x10.
- Backpressure: cfg=2 with in_valid held high for 5 cycles. Exactly 2 beats are accepted, in_ready=0 from the cycle after the 2nd accept, and sample_count=2.
- Zero samples and ignored start: cfg=0 then start gives res_valid 2 cycles later with zeros. A start pulse during DONE does nothing. The result is held until res_ready.
- Clear mid-run: cfg=10, accept 4 erroring beats, then pulse clear. Next cycle: IDLE, busy=0, all statistics 0. A new run with cfg=1 then completes normally.
- Saturation: force sum_abs_err near 2^ACC_W-1 with a reduced ACC_W=8 and beats of error 0x80. The accumulator sticks at 0xFF. With ADDER_ERR_SQ_EN, one beat of error 3 gives sum_sq_err=9.
